cc_bus_ctrl: RTL

CC_BUS_CTRL -- requirements
Module: cc_bus_ctrl

---
 rtl/cc_bus_ctrl_if.sv | 35 +++
 rtl/cc_bus_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cc_bus_ctrl_if.sv
// Bus bundle between the coherence controller, the two caches and memory.
// master = controller side, slave = cache/memory side.
interface cc_bus_ctrl_if;
    logic [1:0]       dREN;
    logic [1:0]       dWEN;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0]       cctrans;
    logic [1:0]       ccwrite;
    logic [1:0]       dwait;
    logic [1:0][31:0] dload;
    logic [1:0]       ccwait;
    logic [1:0]       ccinv;
    logic [1:0][31:0] ccsnoopaddr;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    logic             ramwait;

    modport master (
        input  dREN, dWEN, daddr, dstore, cctrans, ccwrite,
        input  ramload, ramwait,
        output dwait, dload, ccwait, ccinv, ccsnoopaddr,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output dREN, dWEN, daddr, dstore, cctrans, ccwrite,
        output ramload, ramwait,
        input  dwait, dload, ccwait, ccinv, ccsnoopaddr,
        input  ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cc_bus_ctrl.sv
// Two-cache snooping bus controller, 2-word blocks, MSI-style transactions.
// Define CC_C2C_EN to fill the requester directly from a dirty snooped cache.
module cc_bus_ctrl (
    input  logic          CLK,
    input  logic          nRST,
    cc_bus_ctrl_if.master bus
);
    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] ARB   = 4'd1;
    localparam logic [3:0] SNOOP = 4'd2;
    localparam logic [3:0] FWD0  = 4'd3;
    localparam logic [3:0] FWD1  = 4'd4;
    localparam logic [3:0] RD0   = 4'd5;
    localparam logic [3:0] RD1   = 4'd6;
    localparam logic [3:0] WB0   = 4'd7;
    localparam logic [3:0] WB1   = 4'd8;
    localparam logic [3:0] UPG   = 4'd9;

    logic [3:0] state, nstate;
    logic       gnt, ngnt;
    logic       ptr, nptr;
    logic [1:0] req;
    logic       arb;
    logic       r, o;

    assign req = bus.cctrans | bus.dWEN;
    assign r   = gnt;
    assign o   = ~gnt;

    function automatic logic [31:0] waddr(input logic [31:0] a, input logic w);
        return (a & 32'hFFFF_FFF8) | {29'd0, w, 2'b00};
    endfunction

    always_comb begin
        arb = ptr;
        unique case (1'b1)
            (req == 2'b01): arb = 1'b0;
            (req == 2'b10): arb = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        nstate          = state;
        ngnt            = gnt;
        nptr            = ptr;
        bus.dwait       = 2'b11;
        bus.dload       = '0;
        bus.ccwait      = 2'b00;
        bus.ccinv       = 2'b00;
        bus.ccsnoopaddr = '0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = '0;
        bus.ramstore    = '0;
        unique case (state)
            IDLE: if (|req) nstate = ARB;
            ARB: begin
                if (|req) begin
                    ngnt   = arb;
                    nstate = bus.cctrans[arb] ? SNOOP : WB0;
                end else begin
                    nstate = IDLE;
                end
            end
            SNOOP: begin
                bus.ccwait[o]      = 1'b1;
                bus.ccsnoopaddr[o] = bus.daddr[r];
                bus.ccinv[o]       = bus.ccwrite[r];
                if (bus.ccwrite[o])
                    nstate = FWD0;
                else if (bus.ccwrite[r] && !bus.dREN[r])
                    nstate = UPG;
                else
                    nstate = RD0;
            end
            FWD0, FWD1: begin
                bus.ccwait[o] = 1'b1;
                bus.ramWEN    = 1'b1;
                bus.ramaddr   = waddr(bus.daddr[o], state == FWD1);
                bus.ramstore  = bus.dstore[o];
                bus.dwait[o]  = bus.ramwait;
`ifdef CC_C2C_EN
                bus.dload[r]  = bus.dstore[o];
                bus.dwait[r]  = bus.ramwait;
`endif
                if (!bus.ramwait) begin
                    if (state == FWD0) begin
                        nstate = FWD1;
                    end else begin
`ifdef CC_C2C_EN
                        nstate = IDLE;
                        nptr   = o;
`else
                        nstate = RD0;
`endif
                    end
                end
            end
            RD0, RD1: begin
                bus.ramREN   = 1'b1;
                bus.ramaddr  = waddr(bus.daddr[r], state == RD1);
                bus.dload[r] = bus.ramload;
                bus.dwait[r] = bus.ramwait;
                if (!bus.ramwait) begin
                    if (state == RD0) begin
                        nstate = RD1;
                    end else begin
                        nstate = IDLE;
                        nptr   = o;
                    end
                end
            end
            WB0, WB1: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = waddr(bus.daddr[r], state == WB1);
                bus.ramstore = bus.dstore[r];
                bus.dwait[r] = bus.ramwait;
                if (!bus.ramwait) begin
                    if (state == WB0) begin
                        nstate = WB1;
                    end else begin
                        nstate = IDLE;
                        nptr   = o;
                    end
                end
            end
            UPG: begin
                bus.dwait[r] = 1'b0;
                nstate       = IDLE;
                nptr         = o;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            gnt   <= 1'b0;
            ptr   <= 1'b0;
        end else begin
            state <= nstate;
            gnt   <= ngnt;
            ptr   <= nptr;
        end
    end
endmodule
